data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/data_mem_responder.sv | 155 +++++++++++++++
 tb/tb_data_mem_responder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Purpose: request/response bundle between a load/store initiator and data_mem_responder.
// Latency: none, this is wiring only. Backpressure: req_ready and rsp_ready carry it.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_store, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_store, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Purpose: word-organised data memory answering byte/half/word loads and stores; MISALIGN_TRAP_EN traps misaligned half/word.
// Latency: response 1 cycle after acceptance. Backpressure: 2-deep response buffer, req_ready drops when it is full.
module data_mem_responder #(
  parameter int ADDR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  data_mem_responder_if.slave bus
);
  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [1:0] SZ_B  = 2'b00;
  localparam logic [1:0] SZ_H  = 2'b01;
  localparam logic [1:0] SZ_W  = 2'b10;

  logic [31:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] w_idx;
  logic              w_range_err;
  logic              w_mis;
  logic              w_err;
  logic [1:0]        w_lane;
  logic [3:0]        w_be;
  logic [31:0]       w_wd;
  logic              w_acc;
  logic              w_we;
  logic              w_pop;
  logic              w_push;
  logic              w_fpop;
  logic [1:0]        w_occ;
  logic [31:0]       w_s1_rdata;
  logic [7:0]        w_s1_byte;
  logic [15:0]       w_s1_half;
  logic [31:0]       w_head_rdata;
  logic              w_head_err;

  // In-flight stage: raw word read at acceptance, formatted on the way out
  logic              r_s1_vld;
  logic [31:0]       r_s1_word;
  logic [1:0]        r_s1_lane;
  logic [1:0]        r_s1_size;
  logic              r_s1_uns;
  logic              r_s1_err;
  logic              r_s1_st;

  logic [1:0][31:0]  r_q_dat;
  logic [1:0]        r_q_err;
  logic              r_wp;
  logic              r_rp;
  logic [1:0]        r_cnt;

  assign w_idx       = bus.req_addr[ADDR_W+1:2];
  assign w_range_err = |bus.req_addr[31:ADDR_W+2];

`ifdef MISALIGN_TRAP_EN
  assign w_mis = ((bus.req_size == SZ_H) && bus.req_addr[0]) ||
                 ((bus.req_size == SZ_W) && (bus.req_addr[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif

  assign w_err = w_range_err || (bus.req_size == 2'b11) || w_mis;

  always_comb begin
    w_lane = bus.req_addr[1:0];
    w_be   = 4'b0000;
    w_wd   = bus.req_wdata;
    case (bus.req_size)
      SZ_B: begin
        w_be = 4'b0001 << bus.req_addr[1:0];
        w_wd = {4{bus.req_wdata[7:0]}};
      end
      SZ_H: begin
        w_lane = {bus.req_addr[1], 1'b0};
        w_be   = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        w_wd   = {2{bus.req_wdata[15:0]}};
      end
      SZ_W: begin
        w_lane = 2'b00;
        w_be   = 4'b1111;
      end
      default: w_be = 4'b0000;
    endcase
  end

  assign w_occ         = r_cnt + {1'b0, r_s1_vld};
  assign bus.req_ready = !rst && (w_occ < 2'd2);
  assign bus.rsp_valid = !rst && ((r_cnt != 2'd0) || r_s1_vld);
  assign w_acc         = bus.req_valid && bus.req_ready;
  assign w_we          = w_acc && bus.req_store && !w_err;
  assign w_pop         = bus.rsp_valid && bus.rsp_ready;
  assign w_fpop        = (r_cnt != 2'd0) && w_pop;
  assign w_push        = r_s1_vld && !((r_cnt == 2'd0) && w_pop);

  always_ff @(posedge clk) begin
    if (w_we && w_be[0]) r_mem[w_idx][7:0]   <= w_wd[7:0];
    if (w_we && w_be[1]) r_mem[w_idx][15:8]  <= w_wd[15:8];
    if (w_we && w_be[2]) r_mem[w_idx][23:16] <= w_wd[23:16];
    if (w_we && w_be[3]) r_mem[w_idx][31:24] <= w_wd[31:24];
    if (w_acc) r_s1_word <= r_mem[w_idx];
  end

  always_comb begin
    case (r_s1_lane)
      2'd0:    w_s1_byte = r_s1_word[7:0];
      2'd1:    w_s1_byte = r_s1_word[15:8];
      2'd2:    w_s1_byte = r_s1_word[23:16];
      default: w_s1_byte = r_s1_word[31:24];
    endcase
    w_s1_half = r_s1_lane[1] ? r_s1_word[31:16] : r_s1_word[15:0];
    case (r_s1_size)
      SZ_B:    w_s1_rdata = {{24{!r_s1_uns && w_s1_byte[7]}}, w_s1_byte};
      SZ_H:    w_s1_rdata = {{16{!r_s1_uns && w_s1_half[15]}}, w_s1_half};
      SZ_W:    w_s1_rdata = r_s1_word;
      default: w_s1_rdata = 32'h0;
    endcase
    if (r_s1_err || r_s1_st) w_s1_rdata = 32'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_lane <= 2'b00;
      r_s1_size <= 2'b00;
      r_s1_uns  <= 1'b0;
      r_s1_err  <= 1'b0;
      r_s1_st   <= 1'b0;
      r_q_dat   <= '0;
      r_q_err   <= 2'b00;
      r_wp      <= 1'b0;
      r_rp      <= 1'b0;
      r_cnt     <= 2'd0;
    end else begin
      r_s1_vld <= w_acc;
      if (w_acc) begin
        r_s1_lane <= w_lane;
        r_s1_size <= bus.req_size;
        r_s1_uns  <= bus.req_unsigned;
        r_s1_err  <= w_err;
        r_s1_st   <= bus.req_store;
      end
      // A response popped straight from the in-flight stage never enters the buffer
      if (w_push) begin
        r_q_dat[r_wp] <= w_s1_rdata;
        r_q_err[r_wp] <= r_s1_err;
        r_wp          <= ~r_wp;
      end
      if (w_fpop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_fpop};
    end
  end

  assign w_head_rdata  = (r_cnt != 2'd0) ? r_q_dat[r_rp] : w_s1_rdata;
  assign w_head_err    = (r_cnt != 2'd0) ? r_q_err[r_rp] : r_s1_err;
  assign bus.rsp_rdata = bus.rsp_valid ? w_head_rdata : 32'h0;
  assign bus.rsp_err   = bus.rsp_valid && w_head_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// Purpose: directed bench for data_mem_responder (ADDR_W=16), honours MISALIGN_TRAP_EN when defined.
// Latency: expects responses 1 cycle after acceptance. Backpressure: exercises a full buffer and reset with data held.
module tb_data_mem_responder;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  data_mem_responder_if bus_if ();

  data_mem_responder #(.ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd);
    bus_if.req_valid    = 1'b1;
    bus_if.req_store    = st;
    bus_if.req_addr     = addr;
    bus_if.req_size     = size;
    bus_if.req_unsigned = uns;
    bus_if.req_wdata    = wd;
  endtask

  // One request, accepted at the next edge; response must be up the cycle after
  task automatic xact(input string tag, input logic st, input logic [31:0] addr,
                      input logic [1:0] size, input logic uns, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    drive(st, addr, size, uns, wd);
    chk({tag, "_rdy"}, {31'b0, bus_if.req_ready}, 32'd1);
    tick();
    bus_if.req_valid = 1'b0;
    chk({tag, "_vld"}, {31'b0, bus_if.rsp_valid}, 32'd1);
    chk({tag, "_rdata"}, bus_if.rsp_rdata, exp_rd);
    chk({tag, "_err"}, {31'b0, bus_if.rsp_err}, {31'b0, exp_err});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus_if.req_valid    = 1'b0;
    bus_if.req_store    = 1'b0;
    bus_if.req_addr     = 32'h0;
    bus_if.req_size     = 2'b10;
    bus_if.req_unsigned = 1'b0;
    bus_if.req_wdata    = 32'h0;
    bus_if.rsp_ready    = 1'b1;
    tick();
    tick();
    chk("rst_req_ready", {31'b0, bus_if.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, bus_if.rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", bus_if.rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'b0, bus_if.rsp_err}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_req_ready", {31'b0, bus_if.req_ready}, 32'd1);
    tick();

    xact("st_w_dead",  1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("ld_w_dead",  1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
    xact("st_w_1122",  1'b1, 32'h10, 2'b10, 1'b0, 32'h11223344, 32'h0, 1'b0);
    xact("st_b_80",    1'b1, 32'h13, 2'b00, 1'b0, 32'h00000080, 32'h0, 1'b0);
    xact("ld_sb_13",   1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0);
    xact("ld_w_merge", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h80223344, 1'b0);
    xact("ld_ub_13",   1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 32'h00000080, 1'b0);
    xact("ld_sh_12",   1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 32'hFFFF8022, 1'b0);
    xact("ld_uh_12",   1'b0, 32'h12, 2'b01, 1'b1, 32'h0, 32'h00008022, 1'b0);
    xact("ld_sb_10",   1'b0, 32'h10, 2'b00, 1'b0, 32'h0, 32'h00000044, 1'b0);
    xact("st_h_abcd",  1'b1, 32'h10, 2'b01, 1'b0, 32'h1234ABCD, 32'h0, 1'b0);
    xact("ld_w_half",  1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h8022ABCD, 1'b0);
    xact("ld_sb_11",   1'b0, 32'h11, 2'b00, 1'b0, 32'h0, 32'hFFFFFFAB, 1'b0);

    xact("ld_oor",     1'b0, 32'h00040000, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
    xact("st_oor",     1'b1, 32'h00040010, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0, 1'b1);
    xact("ld_after_oor", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h8022ABCD, 1'b0);
    xact("st_rsv",     1'b1, 32'h10, 2'b11, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1);
    xact("ld_rsv",     1'b0, 32'h10, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
    xact("ld_after_rsv", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h8022ABCD, 1'b0);

`ifdef MISALIGN_TRAP_EN
    xact("ld_w_mis12", 1'b0, 32'h12, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
    xact("ld_uh_mis11", 1'b0, 32'h11, 2'b01, 1'b1, 32'h0, 32'h0, 1'b1);
    xact("ld_sh_mis13", 1'b0, 32'h13, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1);
`else
    xact("ld_w_mis12", 1'b0, 32'h12, 2'b10, 1'b0, 32'h0, 32'h8022ABCD, 1'b0);
    xact("ld_uh_mis11", 1'b0, 32'h11, 2'b01, 1'b1, 32'h0, 32'h0000ABCD, 1'b0);
    xact("ld_sh_mis13", 1'b0, 32'h13, 2'b01, 1'b0, 32'h0, 32'hFFFF8022, 1'b0);
`endif

    xact("st_w_55aa", 1'b1, 32'h14, 2'b10, 1'b0, 32'h55AA55AA, 32'h0, 1'b0);
    tick();
    chk("idle_vld", {31'b0, bus_if.rsp_valid}, 32'd0);

    // Backpressure: two loads fill the buffer, third waits for a pop
    bus_if.rsp_ready = 1'b0;
    drive(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    chk("bp_rdy1", {31'b0, bus_if.req_ready}, 32'd1);
    tick();
    drive(1'b0, 32'h14, 2'b10, 1'b0, 32'h0);
    chk("bp_rdy2", {31'b0, bus_if.req_ready}, 32'd1);
    tick();
    drive(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    chk("bp_rdy3_blocked", {31'b0, bus_if.req_ready}, 32'd0);
    chk("bp_vld", {31'b0, bus_if.rsp_valid}, 32'd1);
    chk("bp_head", bus_if.rsp_rdata, 32'h8022ABCD);
    tick();
    chk("bp_rdy3_still", {31'b0, bus_if.req_ready}, 32'd0);
    chk("bp_head_stable", bus_if.rsp_rdata, 32'h8022ABCD);
    chk("bp_err_stable", {31'b0, bus_if.rsp_err}, 32'd0);
    bus_if.rsp_ready = 1'b1;
    chk("bp_rdy_prepop", {31'b0, bus_if.req_ready}, 32'd0);
    tick();
    chk("bp_rdy_postpop", {31'b0, bus_if.req_ready}, 32'd1);
    chk("bp_second", bus_if.rsp_rdata, 32'h55AA55AA);
    tick();
    bus_if.req_valid = 1'b0;
    chk("bp_third_vld", {31'b0, bus_if.rsp_valid}, 32'd1);
    chk("bp_third", bus_if.rsp_rdata, 32'h8022ABCD);
    tick();
    chk("bp_drained", {31'b0, bus_if.rsp_valid}, 32'd0);

    // Reset with two responses buffered; a store held during reset must not land
    bus_if.rsp_ready = 1'b0;
    drive(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h14, 2'b10, 1'b0, 32'h0);
    tick();
    bus_if.req_valid = 1'b0;
    chk("mr_buffered", {31'b0, bus_if.rsp_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_vld", {31'b0, bus_if.rsp_valid}, 32'd0);
    chk("mr_rdy", {31'b0, bus_if.req_ready}, 32'd0);
    chk("mr_rdata", bus_if.rsp_rdata, 32'h0);
    drive(1'b1, 32'h10, 2'b10, 1'b0, 32'h00000000);
    tick();
    tick();
    bus_if.req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mr_rel_rdy", {31'b0, bus_if.req_ready}, 32'd1);
    chk("mr_rel_vld", {31'b0, bus_if.rsp_valid}, 32'd0);
    bus_if.rsp_ready = 1'b1;
    xact("mr_mem_kept", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h8022ABCD, 1'b0);
    xact("mr_mem_kept2", 1'b0, 32'h14, 2'b10, 1'b0, 32'h0, 32'h55AA55AA, 1'b0);
    tick();
    chk("end_idle", {31'b0, bus_if.rsp_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
